// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, one stop bit.
// Bit timing comes from a clk-domain cycle counter; ready/valid handshake, done pulses at frame end.
module uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] send_data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  line,
  output logic                  done
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
  localparam int CW = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // line_d is the level for the next cycle, so line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line_d  = line_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        line_d  = 1'b1;
        ready_d = 1'b1;
        if (valid && ready_q) begin
          shift_d = send_data;
          par_d   = (^send_data) ^ (PARITY == 2);
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
          line_d  = 1'b0;
          ready_d = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          line_d  = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              state_d = ST_PARITY;
              line_d  = par_q;
            end else begin
              state_d = ST_STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            line_d  = shift_d[0];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          line_d  = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          line_d  = 1'b1;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign line  = line_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clk cycles per bit, one instance per parity mode.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] send_data = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
  logic       ready0, line0, done0;
  logic       ready1, line1, done1;
  logic       ready2, line2, done2;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(50000000), .BAUDRATE(5000000), .DATA_WIDTH(8), .PARITY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .send_data(send_data), .valid(valid0),
    .ready(ready0), .line(line0), .done(done0));
  uart_tx #(.CLK_FREQ(50000000), .BAUDRATE(5000000), .DATA_WIDTH(8), .PARITY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .send_data(send_data), .valid(valid1),
    .ready(ready1), .line(line1), .done(done1));
  uart_tx #(.CLK_FREQ(50000000), .BAUDRATE(5000000), .DATA_WIDTH(8), .PARITY(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .send_data(send_data), .valid(valid2),
    .ready(ready2), .line(line2), .done(done2));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // {line, ready, done} of the instance for a parity mode
  function automatic logic [2:0] outs(input int m);
    case (m)
      1:       return {line1, ready1, done1};
      2:       return {line2, ready2, done2};
      default: return {line0, ready0, done0};
    endcase
  endfunction

  task automatic set_valid(input int m, input logic v);
    case (m)
      1:       valid1 = v;
      2:       valid2 = v;
      default: valid0 = v;
    endcase
  endtask

  // pat[i] is the expected line level during bit period i (start bit at index 0).
  task automatic run_frame(input string name, input int mode, input logic [7:0] d,
                           input logic [10:0] pat, input int nbits, input int disturb);
    logic [2:0] o;
    int bad_line, bad_ready, done_cnt, done_at, first_bad;
    bad_line = 0; bad_ready = 0; done_cnt = 0; done_at = -1; first_bad = -1;
    @(negedge clk);
    send_data = d;
    set_valid(mode, 1'b1);
    o = outs(mode);
    check({name, "_ready_before"}, int'(o[1]), 1);
    @(posedge clk);
    #1;
    set_valid(mode, 1'b0);
    send_data = ~d;
    for (int k = 0; k < nbits * 10 + 3; k++) begin
      @(negedge clk);
      o = outs(mode);
      if (k < nbits * 10) begin
        if (o[2] != pat[k / 10]) begin bad_line++; if (first_bad < 0) first_bad = k; end
        if (o[1] != 1'b0) bad_ready++;
      end else begin
        if (o[2] != 1'b1) begin bad_line++; if (first_bad < 0) first_bad = k; end
        if (o[1] != 1'b1) bad_ready++;
      end
      if (o[0]) begin done_cnt++; done_at = k; end
      if (disturb >= 0 && k == disturb) begin send_data = 8'hFF; set_valid(mode, 1'b1); end
      if (disturb >= 0 && k == disturb + 5) set_valid(mode, 1'b0);
    end
    check({name, "_line_bad_cycles"}, bad_line, 0);
    if (bad_line != 0) $display("  first bad line cycle %0d", first_bad);
    check({name, "_ready_bad_cycles"}, bad_ready, 0);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_done_cycle"}, done_at, nbits * 10);
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [7:0]  data;
    logic [10:0] pat;
    int          nbits;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [2:0] o;
    int bad, done_cnt, done1_at, done2_at;
    logic       exp_line, exp_ready;
    logic [9:0] p55, pAA;

    tbl[0] = '{"a5_none", 0, 8'hA5, 11'b0_1_1010_0101_0, 10};
    tbl[1] = '{"07_even", 1, 8'h07, 11'b1_1_0000_0111_0, 11};
    tbl[2] = '{"07_odd",  2, 8'h07, 11'b1_0_0000_0111_0, 11};
    tbl[3] = '{"ff_none", 0, 8'hFF, 11'b0_1_1111_1111_0, 10};
    tbl[4] = '{"80_even", 1, 8'h80, 11'b1_1_1000_0000_0, 11};
    tbl[5] = '{"00_odd",  2, 8'h00, 11'b1_1_0000_0000_0, 11};

    // asynchronous reset state, before any clock edge while in reset
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      o = outs(m);
      check($sformatf("reset_outs_m%0d", m), int'(o), 3'b110);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // idle 100 cycles
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      for (int m = 0; m < 3; m++) if (outs(m) != 3'b110) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].name, tbl[i].mode, tbl[i].data, tbl[i].pat, tbl[i].nbits, -1);

    // inputs change mid-frame while ready=0
    run_frame("disturb_00", 0, 8'h00, 11'b0_1_0000_0000_0, 10, 30);

    // back-to-back with valid held high
    p55 = 10'b1_0101_0101_0;
    pAA = 10'b1_1010_1010_0;
    bad = 0; done_cnt = 0; done1_at = -1; done2_at = -1;
    @(negedge clk);
    send_data = 8'h55;
    valid0 = 1'b1;
    @(posedge clk);
    #1 send_data = 8'hAA;
    for (int k = 0; k < 206; k++) begin
      @(negedge clk);
      if (k < 100)      begin exp_line = p55[k / 10];         exp_ready = 1'b0; end
      else if (k == 100) begin exp_line = 1'b1;               exp_ready = 1'b1; end
      else if (k < 201) begin exp_line = pAA[(k - 101) / 10]; exp_ready = 1'b0; end
      else               begin exp_line = 1'b1;               exp_ready = 1'b1; end
      if (line0 != exp_line || ready0 != exp_ready) bad++;
      if (done0) begin
        done_cnt++;
        if (done_cnt == 1) done1_at = k; else done2_at = k;
      end
      if (k == 101) valid0 = 1'b0;
    end
    check("b2b_bad_cycles", bad, 0);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_done1_cycle", done1_at, 100);
    check("b2b_done2_cycle", done2_at, 201);

    // reset in the middle of a frame
    @(negedge clk);
    send_data = 8'hA5;
    valid0 = 1'b1;
    @(posedge clk);
    #1 valid0 = 1'b0;
    repeat (46) @(negedge clk);
    check("midrst_line_before", int'(line0), 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_line_async", int'(line0), 1);
    check("midrst_ready_async", int'(ready0), 1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done0 || !line0 || !ready0) bad++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done0 || !line0 || !ready0) bad++;
    end
    check("midrst_quiet_cycles", bad, 0);
    run_frame("after_rst_3c", 0, 8'h3C, 11'b0_1_0011_1100_0, 10, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
